pla_engine: RTL



---
 rtl/pla_pkg.sv | 19 +
 rtl/pla_engine_if.sv | 44 ++++
 rtl/pla_term_match.sv | 24 ++
 rtl/pla_engine.sv | 131 +++++++++++++
 4 files changed

// File: rtl/pla_pkg.sv
// Shared cube encoding for the programmable PLA engine.
// Two bits per input variable in espresso order: 10 = needs 1, 01 = needs 0, 11 = don't care, 00 = never.
package pla_pkg;

    typedef logic [1:0] cube_t;

    localparam cube_t CUBE_NULL = 2'b00;
    localparam cube_t CUBE_ZERO = 2'b01;
    localparam cube_t CUBE_ONE  = 2'b10;
    localparam cube_t CUBE_DC   = 2'b11;

    function automatic cube_t encode_cube(input logic value, input logic care);
        if (!care) begin
            return CUBE_DC;
        end
        return value ? CUBE_ONE : CUBE_ZERO;
    endfunction

endpackage

// File: rtl/pla_engine_if.sv
// Bus bundle for pla_engine: input stream, output stream and programming port.
// Optional PLA_OUTPUT_PHASE_EN adds prog_phase_sel for the output-phase register.
interface pla_engine_if #(
    parameter int N_IN    = 82,
    parameter int N_OUT   = 56,
    parameter int N_TERMS = 64
);
    localparam int AW = $clog2(N_TERMS);

    // Both streams use valid/ready: a beat transfers on a rising edge where valid and ready are both high;
    // valid and its payload must hold until that happens, and ready may depend combinationally on valid.
    logic                 in_valid;
    logic                 in_ready;
    logic [N_IN-1:0]      in_x;
    logic                 out_valid;
    logic                 out_ready;
    logic [N_OUT-1:0]     out_z;
    logic                 prog_we;
    logic [AW-1:0]        prog_addr;
    logic [2*N_IN-1:0]    prog_cube_in;
    logic [N_OUT-1:0]     prog_cube_out;
    logic                 prog_ready;
    logic                 prog_err;
`ifdef PLA_OUTPUT_PHASE_EN
    logic                 prog_phase_sel;
`endif

    modport master (
        output in_valid, in_x, out_ready, prog_we, prog_addr, prog_cube_in, prog_cube_out,
`ifdef PLA_OUTPUT_PHASE_EN
        output prog_phase_sel,
`endif
        input  in_ready, out_valid, out_z, prog_ready, prog_err
    );

    modport slave (
        input  in_valid, in_x, out_ready, prog_we, prog_addr, prog_cube_in, prog_cube_out,
`ifdef PLA_OUTPUT_PHASE_EN
        input  prog_phase_sel,
`endif
        output in_ready, out_valid, out_z, prog_ready, prog_err
    );

endinterface

// File: rtl/pla_term_match.sv
// One AND-plane row: checks an input vector against a single programmed cube.
module pla_term_match
    import pla_pkg::*;
#(
    parameter int N_IN = 82
) (
    input  logic [2*N_IN-1:0] cube_i,
    input  logic [N_IN-1:0]   x_i,
    output logic              match_o
);

    cube_t code;

    // A 00 field satisfies neither polarity, so one null variable kills the whole term.
    always_comb begin
        match_o = 1'b1;
        code    = CUBE_NULL;
        for (int i = 0; i < N_IN; i++) begin
            code    = cube_i[2*i +: 2];
            match_o = match_o & ((code == CUBE_DC) || (code == (x_i[i] ? CUBE_ONE : CUBE_ZERO)));
        end
    end

endmodule

// File: rtl/pla_engine.sv
// Runtime-programmable two-stage PLA: stage A registers term matches, stage B registers the OR plane.
// Optional PLA_OUTPUT_PHASE_EN adds a per-output inversion register written at the all-ones slot address.
module pla_engine
    import pla_pkg::*;
#(
    parameter int N_IN    = 82,
    parameter int N_OUT   = 56,
    parameter int N_TERMS = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    pla_engine_if.slave   bus
);

    logic [N_TERMS-1:0][2*N_IN-1:0] cube_q, cube_d;
    logic [N_TERMS-1:0][N_OUT-1:0]  row_q, row_d;
    logic [N_TERMS-1:0]             match_c, match_a_q, match_a_d;
    logic                           a_valid_q, a_valid_d;
    logic                           b_valid_q, b_valid_d;
    logic [N_OUT-1:0]               z_q, z_d, or_c, out_phase;
    logic                           prog_err_q, prog_err_d;
    logic                           prog_ready, write_ok, slot_we;
    logic                           a_adv, in_ready, accept;

    assign prog_ready = !a_valid_q && !b_valid_q;
    assign write_ok   = bus.prog_we && prog_ready;

`ifdef PLA_OUTPUT_PHASE_EN
    logic [N_OUT-1:0] phase_q, phase_d;

    // A phase-select write to any address other than all-ones touches nothing.
    assign slot_we   = write_ok && !bus.prog_phase_sel;
    assign out_phase = phase_q;

    always_comb begin
        phase_d = phase_q;
        if (write_ok && bus.prog_phase_sel && (&bus.prog_addr)) begin
            phase_d = bus.prog_cube_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end
`else
    assign slot_we   = write_ok;
    assign out_phase = '0;
`endif

    for (genvar t = 0; t < N_TERMS; t++) begin : g_term
        pla_term_match #(.N_IN(N_IN)) u_match (
            .cube_i  (cube_q[t]),
            .x_i     (bus.in_x),
            .match_o (match_c[t])
        );
    end

    always_comb begin
        or_c = '0;
        for (int t = 0; t < N_TERMS; t++) begin
            if (match_a_q[t]) begin
                or_c = or_c | row_q[t];
            end
        end
    end

    always_comb begin
        cube_d     = cube_q;
        row_d      = row_q;
        prog_err_d = prog_err_q || (bus.prog_we && !prog_ready);
        if (slot_we) begin
            cube_d[bus.prog_addr] = bus.prog_cube_in;
            row_d[bus.prog_addr]  = bus.prog_cube_out;
        end
    end

    // prog_we blocks accepts, so no vector is ever evaluated against half-written storage.
    assign a_adv    = !b_valid_q || bus.out_ready;
    assign in_ready = !bus.prog_we && (!a_valid_q || a_adv);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        a_valid_d = a_valid_q;
        match_a_d = match_a_q;
        b_valid_d = b_valid_q;
        z_d       = z_q;
        if (!a_valid_q || a_adv) begin
            a_valid_d = accept;
            if (accept) begin
                match_a_d = match_c;
            end
        end
        if (a_adv) begin
            b_valid_d = a_valid_q;
            if (a_valid_q) begin
                z_d = or_c ^ out_phase;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cube_q     <= '0;
            row_q      <= '0;
            match_a_q  <= '0;
            a_valid_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            z_q        <= '0;
            prog_err_q <= 1'b0;
        end else begin
            cube_q     <= cube_d;
            row_q      <= row_d;
            match_a_q  <= match_a_d;
            a_valid_q  <= a_valid_d;
            b_valid_q  <= b_valid_d;
            z_q        <= z_d;
            prog_err_q <= prog_err_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = b_valid_q;
    assign bus.out_z      = z_q;
    assign bus.prog_ready = prog_ready;
    assign bus.prog_err   = prog_err_q;

endmodule
